// File: rtl/fetch_pkg.sv
// fetch_pkg: shared encodings and constants for the instruction fetch sequencer.
`default_nettype none

package fetch_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  // MIPS primary opcodes; the bench assembles words from these.
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // Sign-extended word offset converted to a byte displacement.
  function automatic logic [31:0] branch_disp(input logic [15:0] off);
    return {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_target_calc.sv
// branch_target_calc: MIPS branch target (pc + 4 + offset*4) with misalignment flag.
`default_nettype none

module branch_target_calc
  import fetch_pkg::*;
(
  input  logic [31:0] redir_pc,
  input  logic [15:0] redir_off,
  output logic [31:0] target,
  output logic        misalign
);

  logic [31:0] target_raw;

  always_comb begin
    target_raw = redir_pc + PC_STEP + branch_disp(redir_off);
    misalign   = |target_raw[1:0];
    target     = {target_raw[31:2], 2'b00};
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: PC owner, one-entry fetch register, redirect and halt handling.
// Optional IFS_ALIGN_FAULT_EN adds fetch_fault and a FAULT state for misaligned redirects.
`default_nettype none

module instr_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int          IMEM_BYTES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [31:0]        if_pc,
  input  logic               redir_valid,
  input  logic [31:0]        redir_pc,
  input  logic [15:0]        redir_off,
  input  logic               halt_req,
  output logic               halted
`ifdef IFS_ALIGN_FAULT_EN
  ,
  output logic               fetch_fault
`endif
);

  localparam logic [31:0] PC_MASK = 32'(IMEM_BYTES - 1);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [31:0]        if_pc_q, if_pc_d;
  logic               halted_q, halted_d;

  logic [31:0] tgt;
  logic        tgt_misalign;
  logic        slot_free;
  logic        consume;

  branch_target_calc u_btc (
    .redir_pc  (redir_pc),
    .redir_off (redir_off),
    .target    (tgt),
    .misalign  (tgt_misalign)
  );

`ifdef IFS_ALIGN_FAULT_EN
  logic fault_q, fault_d;
`else
  logic unused_misalign;
  assign unused_misalign = tgt_misalign;
`endif

  assign slot_free = !if_valid_q || if_ready;
  assign consume   = if_valid_q && if_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
`ifdef IFS_ALIGN_FAULT_EN
    fault_d    = fault_q;
`endif

    case (state_q)
      ST_START: state_d = ST_RUN;
      default: begin
        if (redir_valid) begin
          // Redirect wins over everything: flush even a stalled entry.
          pc_d       = tgt & PC_MASK;
          if_valid_d = 1'b0;
          if (state_q == ST_RUN && halt_req) state_d = ST_HALT;
`ifdef IFS_ALIGN_FAULT_EN
          if (tgt_misalign) begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end
`endif
        end else if (state_q == ST_RUN && !halt_req) begin
          if (slot_free) begin
            if_instr_d = imem_data;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = (pc_q + PC_STEP) & PC_MASK;
          end
        end else begin
          // Halting: stop capturing, but let decode drain the pending entry.
          if (state_q == ST_RUN) state_d = ST_HALT;
          if (consume) if_valid_d = 1'b0;
        end
      end
    endcase

    halted_d = (state_d == ST_HALT || state_d == ST_FAULT) && !if_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_START;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      halted_q   <= halted_d;
    end
  end

`ifdef IFS_ALIGN_FAULT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end
  assign fetch_fault = fault_q;
`endif

  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign halted    = halted_q;

endmodule

`default_nettype wire

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- Owns the program counter and sequences the combinational instruction memory.
- Drives the memory address, captures the returned instruction into a one-entry fetch register, and hands it to decode with a valid/ready handshake.
- Accepts branch redirects from execute, with MIPS target arithmetic.
- Accepts a halt request that stops fetching.

Parameters:
- RESET_PC, 32'd0, PC value after reset.
- IMEM_BYTES, 1024, instruction address space size in bytes; power of two, ≥ 8; PC wraps modulo this value.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  32  byte address to instruction memory; equals the PC register.
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- if_valid  out  1  fetch register holds an instruction.
- if_ready  in  1  decode accepts the instruction this cycle.
- if_instr  out  32  fetched instruction.
- if_pc  out  32  address the instruction was fetched from.
- redir_valid  in  1  branch taken; redirect this cycle.
- redir_pc  in  32  address of the branch instruction.
- redir_off  in  16  signed word offset from the branch immediate.
- halt_req  in  1  stop fetching.
- halted  out  1  sequencer is in HALT and the fetch register is empty.

Behaviour:
- Reset (asynchronous, immediate while rst_n=0):
  - pc=RESET_PC, so imem_addr=RESET_PC.
  - if_valid=0, if_instr=0, if_pc=0, halted=0.
  - state=START.
  - Reset asserted mid-operation discards any in-flight instruction.
- States: START, RUN, HALT.
  - START→RUN on the first clock edge after rst_n deasserts; no capture in START.
  - RUN→HALT at the edge where halt_req=1.
  - HALT exits only by reset.
- Capture condition, in RUN: slot_free = !if_valid || if_ready.
  - If slot_free and no redirect: if_instr<=imem_data, if_pc<=pc, if_valid<=1, pc<=(pc+4) mod IMEM_BYTES.
  - If if_valid && !if_ready: hold if_instr, if_pc, if_valid and pc unchanged (stall).
- Latency:
  - First instruction is valid 2 edges after reset release.
  - Throughput is 1 instruction per cycle while if_ready=1.
- Redirect (any state except START, highest priority):
  - target = redir_pc + 4 + (sign_extend(redir_off) << 2), truncated to 32 bits, then mod IMEM_BYTES.
  - At that edge: pc<=target, if_valid<=0 (flush, even if stalled), no capture.
  - Next RUN edge fetches target.
- Redirect + halt_req at the same edge: pc<=target, flush, state→HALT.
- Redirect + if_ready at the same edge: the decode handshake completes (the instruction is consumed) and the flush still applies.
- HALT:
  - No captures and pc is frozen.
  - A pending if_valid remains until if_ready, then clears.
  - halted=1 from the cycle after the fetch register becomes empty.
- Wrap-around:
  - pc = IMEM_BYTES-4 increments to 0.
  - Negative or oversized targets also reduce mod IMEM_BYTES.
- Alignment: the low two bits of target are forced to 0 (see Optional Feature).
- halt_req held in HALT has no further effect.

Optional Feature:
- Macro: IFS_ALIGN_FAULT_EN.
- Defined:
  - Adds output port fetch_fault (1 bit, reset 0) and state FAULT.
  - A redirect whose unmasked target[1:0]≠0 sets fetch_fault=1, flushes, and enters FAULT.
  - FAULT behaves as HALT, with halted=1 once empty.
  - Exit by reset only.
- Undefined:
  - No fetch_fault port.
  - target[1:0] is silently cleared and fetching continues.

Decomposition:
- Shared package fetch_pkg:
  - State encodings START/RUN/HALT/FAULT.
  - INSTR_W=32, PC_STEP=4.
  - Opcode constants ADDI/BEQ/BNE/LW/SW/R, used by the bench to build words.
- One natural sub-module: branch_target_calc.
  - Combinational: redir_pc, redir_off → target plus misalign flag.
  - Reused later by the execute stage.

Test Plan:
- Reset and stream: release rst_n, if_ready=1, memory holds 5 words at 0..16 → if_valid rises on edge 2; if_pc sequence 0,4,8,12,16; if_instr at 16 = 32'h1001FFFD.
- Backpressure:
  - Drop if_ready for 3 cycles while if_pc=8 → if_instr and if_pc hold and imem_addr stays 12.
  - Raise if_ready → if_pc 12 on the next edge.
- Branch: redir_valid with redir_pc=16, redir_off=-3 → next edge if_valid=0 and pc=8; following edge if_pc=8.
- Halt collision: halt_req with redir_valid (redir_pc=0, off=1) in the same cycle → pc=8, state HALT, no further captures, halted=1.
- Wrap: IMEM_BYTES=1024, run from pc=1020 → next if_pc=0; redirect redir_pc=0, off=-2 → target wraps to 1020.
- Mid-op reset:
  - Assert rst_n=0 while stalled at if_pc=12 → all outputs reach reset values with no clock.
  - With IFS_ALIGN_FAULT_EN: redirect target 8, mutated to 10 → fetch_fault=1.
